maxnet_engine: RTL
==================

Name: maxnet_engine

Overview:
Parametrised MaxNet winner-take-all engine: N signed fixed-point channels iterate x_i <- ReLU(x_i - eps*sum_{j!=i} x_j) until at most one channel stays positive. Own FSM controller with start/done handshake; a single time-multiplexed inhibition multiplier replaces per-channel processing units. Reports winner index, the winner's original input value, iteration count and timeout. Sits between input staging registers and downstream consumers of the max result.

Parameters:
N, 4, channel count (>=2)
W, 32, data width, signed two's complement
FRAC, 16, fractional bits of data and epsilon (Q(W-FRAC).FRAC)
MAX_ITER, 64, iteration limit before timeout (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
start  in  1  request; accepted only when ready=1
ready  out  1  high in IDLE
epsilon  in  W  unsigned inhibition weight, sampled at start
in_vec  in  N*W  channel i at bits [i*W +: W], sampled at start
done  out  1  one-cycle completion pulse
found  out  1  exactly one winner resolved
timeout  out  1  MAX_ITER reached with >=2 positives
max_idx  out  $clog2(N)  winner index
max_val  out  W  winner's original (pre-ReLU) input
iter_count  out  $clog2(MAX_ITER+1)  iterations performed

Behaviour:
- Reset (rst=0): state IDLE, ready=1; done, found, timeout, max_idx, max_val, iter_count, and all internal registers = 0. Reset mid-operation aborts; no done pulse.
- IDLE: start&&ready at edge T: capture originals orig_i=in_vec_i, act_i=max(in_vec_i,0), eps=epsilon; clear iter_count, found, timeout; go CHECK. start ignored outside IDLE.
- CHECK (1 cycle): P = number of act_i>0. P==1 -> found=1, max_idx=that channel, max_val=orig of that channel, go DONE. P==0 -> found=0, max_idx=0, max_val=0, go DONE. P>=2 and iter_count==MAX_ITER -> timeout=1, found=0, max_idx=0, max_val=0, go DONE. Otherwise go SUM.
- SUM (N cycles): S = sum of act_i accumulated in a W+$clog2(N) bit register.
- UPDATE (N cycles, channel k on cycle k): prod = (eps*(S-act_k))>>>FRAC, floor truncation, full-width product. new = act_k - prod; negative -> 0. All new values are written to a shadow buffer and committed together on the last UPDATE cycle; iter_count++ on commit; go CHECK.
- Each iteration costs 2N+1 cycles. Zero-iteration result: done high in cycle T+2.
- DONE: done=1 for one cycle, then IDLE. Results hold until the next accepted start.
- Overflow: act_i>=0 and eps>=0, so new <= act_k; only the negative clamp is needed.

Optional Feature:
TIE_BREAK_EN: defined -> CHECK stores the previous positive mask; if P drops from >=2 to 0, found=1, max_idx=lowest index in the previous mask, max_val=its orig. Undefined -> that case reports found=0 as above.

Decomposition:
- maxnet_pkg: FSM state enum (IDLE, CHECK, SUM, UPDATE, DONE), index/count width functions, Q-format constants.
- Sub-module maxnet_inhibit_unit: combinational multiply, shift, subtract and ReLU clamp for one channel, instantiated once.

Test Plan:
(Test values use N=4, W=32, FRAC=16.)
- in={0,0,5.0,0}, eps=0.5 -> done at T+2, found=1, max_idx=2, max_val=0x0005_0000, iter_count=0.
- in={1.0,0.5,0,0}, eps=0x8000 -> one iteration, done at T+11, found=1, max_idx=0, max_val=0x0001_0000, iter_count=1.
- in={-3.0,-1.0,0,-2.0} -> done at T+2, found=0, max_idx=0, max_val=0, timeout=0.
- in={2.0,2.0,0,0}, eps=0x10000 -> without macro: found=0, iter_count=1. With TIE_BREAK_EN: found=1, max_idx=0, max_val=0x0002_0000.
- in={2.0,2.0,0,0}, eps=0x8000, MAX_ITER=8 -> timeout=1, found=0, iter_count=8.
- rst pulsed low during UPDATE, then a new start with case 2 -> no stale done; correct result; start held high while busy is ignored.

Source files
------------

// File: rtl/maxnet_pkg.sv
// Shared types and helpers for the MaxNet winner-take-all engine.
// FSM state encoding, width helpers and Q-format defaults.
package maxnet_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_SUM    = 3'd2,
        S_UPDATE = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    localparam int Q_W_DEFAULT    = 32;
    localparam int Q_FRAC_DEFAULT = 16;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int count_width(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/maxnet_inhibit_unit.sv
// One-channel MaxNet update: act - floor(eps * (sum - act) >> FRAC), clamped at zero.
// Inputs are non-negative, so the result never exceeds act and only the low clamp exists.
module maxnet_inhibit_unit #(
    parameter int W    = 32,
    parameter int FRAC = 16,
    parameter int SW   = 34
) (
    input  logic [W-1:0]  act,
    input  logic [W-1:0]  eps,
    input  logic [SW-1:0] sum,
    output logic [W-1:0]  act_new
);

    localparam int PW = W + SW;

    logic [SW-1:0] other_s;
    logic [PW-1:0] prod_full_s;
    logic [PW-1:0] prod_s;
    logic [PW-1:0] act_ext_s;

    // Full-width inhibition product and ReLU clamp.
    always_comb begin
        other_s     = sum - {{(SW - W){1'b0}}, act};
        prod_full_s = {{W{1'b0}}, other_s} * {{SW{1'b0}}, eps};
        prod_s      = prod_full_s >> FRAC;
        act_ext_s   = {{SW{1'b0}}, act};
        if (prod_s >= act_ext_s) begin
            act_new = '0;
        end else begin
            act_new = act - prod_s[W-1:0];
        end
    end

endmodule

// File: rtl/maxnet_engine.sv
// MaxNet winner-take-all engine with a single time-multiplexed inhibition unit.
// Optional macro TIE_BREAK_EN: a collapse from >=2 positives to 0 picks the lowest previous survivor.
module maxnet_engine
    import maxnet_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = 32,
    parameter int FRAC     = 16,
    parameter int MAX_ITER = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           ready,
    input  logic [W-1:0]                   epsilon,
    input  logic [N*W-1:0]                 in_vec,
    output logic                           done,
    output logic                           found,
    output logic                           timeout,
    output logic [$clog2(N)-1:0]           max_idx,
    output logic [W-1:0]                   max_val,
    output logic [$clog2(MAX_ITER+1)-1:0]  iter_count
);

    localparam int LN = idx_width(N);
    localparam int IW = count_width(MAX_ITER);
    localparam int SW = W + LN;
    localparam int PW = LN + 1;

    state_e         state_r, state_nx;
    logic [W-1:0]   orig_r   [N];
    logic [W-1:0]   act_r    [N];
    logic [W-1:0]   shadow_r [N];
    logic [W-1:0]   eps_r;
    logic [SW-1:0]  sum_r;
    logic [LN-1:0]  cnt_r;
    logic [IW-1:0]  iter_r;
    logic           done_r, ready_r, found_r, timeout_r;
    logic [LN-1:0]  max_idx_r;
    logic [W-1:0]   max_val_r;

    logic [N-1:0]   pos_mask_s;
    logic [PW-1:0]  pop_s;
    logic [LN-1:0]  first_s;
    logic           cnt_last_s, iter_max_s;
    logic           res_found_s, res_timeout_s;
    logic [LN-1:0]  res_idx_s;
    logic [W-1:0]   res_val_s;
    logic [W-1:0]   act_new_s;
    logic           done_s, ready_s;

`ifdef TIE_BREAK_EN
    logic [N-1:0]   prev_mask_r;
    logic           prev_multi_r;
    logic [LN-1:0]  prev_first_s;
`endif

    maxnet_inhibit_unit #(.W(W), .FRAC(FRAC), .SW(SW)) u_inhibit (
        .act     (act_r[cnt_r]),
        .eps     (eps_r),
        .sum     (sum_r),
        .act_new (act_new_s)
    );

    // Positive-channel mask, population count and lowest positive index.
    always_comb begin
        pos_mask_s = '0;
        pop_s      = '0;
        first_s    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            pos_mask_s[i] = (act_r[i] != '0);
            pop_s         = pop_s + {{(PW - 1){1'b0}}, pos_mask_s[i]};
            first_s       = pos_mask_s[i] ? LN'(i) : first_s;
        end
        cnt_last_s = (cnt_r == LN'(N - 1));
        iter_max_s = (iter_r == IW'(MAX_ITER));
    end

`ifdef TIE_BREAK_EN
    // Lowest index among the survivors of the previous iteration.
    always_comb begin
        prev_first_s = '0;
        for (int i = N - 1; i >= 0; i--) begin
            prev_first_s = prev_mask_r[i] ? LN'(i) : prev_first_s;
        end
    end
`endif

    // Result of the convergence check in the current CHECK cycle.
    always_comb begin
        res_found_s   = 1'b0;
        res_timeout_s = 1'b0;
        res_idx_s     = '0;
        res_val_s     = '0;
        if (pop_s == PW'(1)) begin
            res_found_s = 1'b1;
            res_idx_s   = first_s;
            res_val_s   = orig_r[first_s];
        end else if (pop_s == PW'(0)) begin
`ifdef TIE_BREAK_EN
            res_found_s = prev_multi_r;
            res_idx_s   = prev_multi_r ? prev_first_s : '0;
            res_val_s   = prev_multi_r ? orig_r[prev_first_s] : '0;
`else
            res_found_s = 1'b0;
`endif
        end else begin
            res_timeout_s = iter_max_s;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            S_IDLE:   state_nx = start ? S_CHECK : S_IDLE;
            S_CHECK:  state_nx = (pop_s < PW'(2) || iter_max_s) ? S_DONE : S_SUM;
            S_SUM:    state_nx = cnt_last_s ? S_UPDATE : S_SUM;
            S_UPDATE: state_nx = cnt_last_s ? S_CHECK : S_UPDATE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Handshake outputs, registered one cycle later so they line up with the state.
    always_comb begin
        done_s  = (state_r == S_CHECK) && (state_nx == S_DONE);
        ready_s = (state_nx == S_IDLE);
    end

    // Datapath: capture, accumulate, update/commit and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                orig_r[i]   <= '0;
                act_r[i]    <= '0;
                shadow_r[i] <= '0;
            end
            eps_r     <= '0;
            sum_r     <= '0;
            cnt_r     <= '0;
            iter_r    <= '0;
            done_r    <= 1'b0;
            ready_r   <= 1'b1;
            found_r   <= 1'b0;
            timeout_r <= 1'b0;
            max_idx_r <= '0;
            max_val_r <= '0;
`ifdef TIE_BREAK_EN
            prev_mask_r  <= '0;
            prev_multi_r <= 1'b0;
`endif
        end else begin
            done_r  <= done_s;
            ready_r <= ready_s;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N; i++) begin
                            orig_r[i] <= in_vec[i*W +: W];
                            act_r[i]  <= in_vec[i*W + W - 1] ? '0 : in_vec[i*W +: W];
                        end
                        eps_r     <= epsilon;
                        iter_r    <= '0;
                        found_r   <= 1'b0;
                        timeout_r <= 1'b0;
`ifdef TIE_BREAK_EN
                        prev_mask_r  <= '0;
                        prev_multi_r <= 1'b0;
`endif
                    end
                end
                S_CHECK: begin
                    sum_r <= '0;
                    cnt_r <= '0;
                    if (state_nx == S_DONE) begin
                        found_r   <= res_found_s;
                        timeout_r <= res_timeout_s;
                        max_idx_r <= res_idx_s;
                        max_val_r <= res_val_s;
                    end else begin
`ifdef TIE_BREAK_EN
                        prev_mask_r  <= pos_mask_s;
                        prev_multi_r <= 1'b1;
`endif
                    end
                end
                S_SUM: begin
                    sum_r <= sum_r + {{LN{1'b0}}, act_r[cnt_r]};
                    cnt_r <= cnt_last_s ? '0 : cnt_r + LN'(1);
                end
                S_UPDATE: begin
                    shadow_r[cnt_r] <= act_new_s;
                    cnt_r           <= cnt_last_s ? '0 : cnt_r + LN'(1);
                    // All channels switch together so every update in this pass saw the same S.
                    if (cnt_last_s) begin
                        for (int i = 0; i < N; i++) begin
                            act_r[i] <= (cnt_r == LN'(i)) ? act_new_s : shadow_r[i];
                        end
                        iter_r <= iter_r + IW'(1);
                    end
                end
                S_DONE: begin
                    cnt_r <= '0;
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    assign ready      = ready_r;
    assign done       = done_r;
    assign found      = found_r;
    assign timeout    = timeout_r;
    assign max_idx    = max_idx_r;
    assign max_val    = max_val_r;
    assign iter_count = iter_r;

endmodule
